sync_fifo_wr_arb: RTL

//  Round-robin write-port arbiter sharing one sync_fifo between NUM_REQ producers.

---
 rtl/sync_fifo_wr_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin write-port arbiter that shares one sync_fifo between NUM_REQ
// producers. One producer is granted per beat. Its data is muxed onto the FIFO write port with
// zero-cycle accept. A granted producer keeps the port for up to MAX_BURST consecutive beats.
//
// Optional feature: define FIFO_ARB_STATS_EN to add beat_cnt_o. It holds one 16-bit saturating
// accepted-beat counter per producer.
//
// Ports:
//   clk_i           clock
//   rstn_i          synchronous reset, active low
//   req_i           req_i[i]=1: producer i presents a beat on slice i of req_data_i
//   req_data_i      slice i = req_data_i[i*DATA_WID +: DATA_WID]
//   gnt_o           one-hot/zero; gnt_o[i]=1: beat of producer i accepted this cycle
//   fifo_full_i     downstream sync_fifo full
//   fifo_wr_en_o    downstream wr_en (= |gnt_o)
//   fifo_data_in_o  data of granted producer, else 0
//   owner_o         locked producer index, 0 when idle
//   beat_cnt_o      (FIFO_ARB_STATS_EN only) per-producer accepted-beat counters
//   busy_o          1 while a burst lock is held
module sync_fifo_wr_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_WID  = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WID-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WID-1:0]           fifo_data_in_o,
  output logic [$clog2(NUM_REQ)-1:0]    owner_o,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]         beat_cnt_o,
`endif
  output logic                          busy_o
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q;
  idx_t             rr_ptr_q;
  idx_t             owner_q;
  logic [BeatW-1:0] beats_q;

  idx_t sel;
  logic sel_vld;
  logic accept;

  function automatic idx_t next_idx(input idx_t i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + idx_t'(1);
  endfunction

  // Selection: round-robin scan from rr_ptr_q when idle, locked owner during a burst.
  always_comb begin
    int unsigned scan;
    scan    = 0;
    sel     = owner_q;
    sel_vld = 1'b0;
    if (state_q == StIdle) begin
      sel = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan = 32'(rr_ptr_q) + k;
        if (scan >= NUM_REQ) scan = scan - NUM_REQ;
        if (!sel_vld && req_i[idx_t'(scan)]) begin
          sel     = idx_t'(scan);
          sel_vld = 1'b1;
        end
      end
    end else begin
      sel_vld = req_i[owner_q];
    end
  end

  assign accept = sel_vld & ~fifo_full_i & rstn_i;

  always_comb begin
    gnt_o          = '0;
    fifo_data_in_o = '0;
    if (accept) begin
      gnt_o[sel]     = 1'b1;
      fifo_data_in_o = req_data_i[32'(sel)*DATA_WID +: DATA_WID];
    end
  end

  assign fifo_wr_en_o = accept;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q == StBurst);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beats_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (MAX_BURST > 1) begin
              state_q <= StBurst;
              owner_q <= sel;
              beats_q <= BeatW'(1);
            end else begin
              rr_ptr_q <= next_idx(sel);
            end
          end
        end
        StBurst: begin
          // Owner withdrew: release without a grant this cycle (one-cycle bubble).
          if (!req_i[owner_q]) begin
            state_q  <= StIdle;
            rr_ptr_q <= next_idx(owner_q);
            owner_q  <= '0;
            beats_q  <= '0;
          end else if (accept) begin
            if (beats_q + BeatW'(1) == BeatW'(MAX_BURST)) begin
              state_q  <= StIdle;
              rr_ptr_q <= next_idx(owner_q);
              owner_q  <= '0;
              beats_q  <= '0;
            end else begin
              beats_q <= beats_q + BeatW'(1);
            end
          end
          // Full with owner requesting: stall, lock and beat count held.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        cnt_q[i] <= '0;
      end else if (gnt_o[i] && cnt_q[i] != 16'hFFFF) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
    assign beat_cnt_o[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule
